multicycle_ctrl: RTL

- Main sequencing FSM for the multicycle ARM-subset datapath.
- Produces the enable strobes for the datapath's enabled registers: IR, PC, register file and data memory.
- Produces the mux selects and ALU mode for each cycle.
- Waits on a memory-ready handshake so that fetch and data accesses can take multiple cycles.

---
 rtl/multicycle_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle ARM-subset datapath: register enables,
// mux selects and ALU mode, with a memory-ready handshake on fetch/load/store.
`timescale 1ns/1ps

module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       next_pc,
  output logic       branch,
  output logic       reg_w,
  output logic       mem_w,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_ir_write;
  logic w_next_pc;
  logic w_branch;
  logic w_reg_w;
  logic w_mem_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          2'b00:   w_state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_state_next = S_MEMADR;
          2'b10:   w_state_next = S_BRANCH;
          default: w_state_next = S_FETCH;  // undefined op retires as a NOP
        endcase
      end
      S_MEMADR:   w_state_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    w_state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTER: w_state_next = S_ALUWB;
      S_EXECUTEI: w_state_next = S_ALUWB;
      default:    w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ir_write = 1'b0;
    w_next_pc  = 1'b0;
    w_branch   = 1'b0;
    w_reg_w    = 1'b0;
    w_mem_w    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = mem_ready;
        w_next_pc  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMRD:    adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        w_reg_w    = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        w_mem_w = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB:    w_reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        w_branch   = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is high so an aborted instruction commits nothing.
  assign ir_write = w_ir_write & ~reset;
  assign next_pc  = w_next_pc  & ~reset;
  assign branch   = w_branch   & ~reset;
  assign reg_w    = w_reg_w    & ~reset;
  assign mem_w    = w_mem_w    & ~reset;
  assign state    = r_state;

endmodule
